keypad_scan: RTL
================

// Module: keypad_scan
// PURPOSE
//  Scans a 4x4 active-low matrix keypad and produces debounced 4-bit key codes (0-15), the
//  same encoding the seven-segment driver consumes on its digit input. Producer end of the
//  digit-code path: keypad -> keypad_scan -> locker control -> seven-segment driver.
//  One key per press. key_valid pulses once per press; repeats are never emitted.
// PARAMETERS
//  SCAN_DIV      1000  clk cycles each column is driven (dwell); rows sampled on last cycle
//  DEBOUNCE_CNT  20    consecutive matching samples required to accept a press or a release
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  rst_n       in   1  asynchronous active-low reset
//  row_in      in   4  keypad rows, active-low (pulled up externally), asynchronous to clk
//  col_out     out  4  keypad column drive, one-hot active-low
//  key_number  out  4  code of last accepted key; holds until the next accepted press
//  key_valid   out  1  single-cycle pulse when key_number is updated by an accepted press
//  key_held    out  1  high from accepted press until accepted release
// BEHAVIOUR
//  Reset (async, rst_n=0): col_out=4'b1110, key_number=0, key_valid=0, key_held=0,
//   state=SCAN, all counters 0, synchronizer flops 4'b1111.
//  row_in passes through 2-flop synchronizer; all decisions use the synchronized value (rows_s).
//  Dwell counter: 0..SCAN_DIV-1, wraps; "sample" = cycle where counter==SCAN_DIV-1.
//  Column index c (0..3) drives col_out=~(1<<c). Advances only in SCAN, on sample, 3 wraps to 0.
//  Valid hit: rows_s has exactly one 0 bit (row r). Zero or >=2 low rows = no hit.
//  FSM:
//   SCAN     : on sample with valid hit -> latch (r,c), deb=1, DEBOUNCE; column frozen.
//              on sample with no hit -> advance column.
//   DEBOUNCE : on sample: same single row r low -> deb++; else -> SCAN (deb=0, advance column).
//              when deb reaches DEBOUNCE_CNT -> key_number<=KEYMAP[r][c], key_valid=1 for the
//              next cycle only, key_held<=1, deb=0, PRESSED.
//   PRESSED  : column frozen. on sample: rows_s==4'b1111 -> deb++, else deb=0.
//              deb reaches DEBOUNCE_CNT -> key_held<=0, deb=0, SCAN (column advances).
//   Second key pressed while PRESSED (rows_s not all-high, any pattern): no effect, resets deb.
//  DEBOUNCE_CNT=1: press accepted on the first hit sample (SCAN goes directly to accept).
//  key_valid and key_number update in the same cycle; key_valid never high two cycles running.
//  Latency (key stable): <= 4*SCAN_DIV (reach column) + 2 (sync) + (DEBOUNCE_CNT-1)*SCAN_DIV + 1.
//  KEYMAP[row][col]: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E(*) 0 F(#) D
//   (A=10,B=11,C=12,D=13,*=14,#=15). Codes 10-15 display blank downstream; control uses them.
//  Reset mid-press: everything returns to reset values; a key still held after reset is
//   re-detected and accepted as a new press (one key_valid).
//  Counter widths: $clog2(SCAN_DIV), $clog2(DEBOUNCE_CNT+1); no overflow (saturating compare).
// STRUCTURE
//  keypad_pkg: state enum {SCAN, DEBOUNCE, PRESSED}, KEYMAP 4x4 constant, key code constants
//   (KEY_A..KEY_D, KEY_STAR=14, KEY_HASH=15), ROWS=4, COLS=4.
//  Sub-module keypad_sync: 4-bit 2-flop synchronizer, reset to all-ones.
//  Top: dwell counter, column register, FSM, debounce counter, output registers.
// TESTING (bench with SCAN_DIV=4, DEBOUNCE_CNT=3; keypad model drives row low when its
//  column is driven low and key closed)
//  Reset: rst_n=0 -> col_out=1110, key_number=0, key_valid=0, key_held=0; then columns rotate
//   1110->1101->1011->0111->1110 every 4 cycles.
//  Press '5' (r1,c1) held: exactly one key_valid, key_number=5, key_held=1; col_out frozen at
//   1101 while held; release -> key_held=0 after 3 idle samples, scanning resumes.
//  Bounce: '9' toggled closed/open every 5 cycles for 60 cycles then closed -> no key_valid
//   during bounce, exactly one key_valid with key_number=9 after stable.
//  Two keys same column ('1','4') together -> no key_valid; second key ('#') pressed while '2'
//   held -> only one key_valid (key_number=2), '#' ignored until '2' released and re-scanned.
//  Assert rst_n low while '0' held in PRESSED -> outputs reset immediately (async); after
//   release of reset with '0' still held -> one key_valid, key_number=0.
//  All 16 keys pressed/released in turn -> key_number sequence matches KEYMAP, 16 pulses.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_e;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Key code for each [row][column] crossing of the matrix.
    localparam logic [3:0] KEYMAP [ROWS][COLS] = '{
        '{4'd1,     4'd2, 4'd3,     KEY_A},
        '{4'd4,     4'd5, 4'd6,     KEY_B},
        '{4'd7,     4'd8, 4'd9,     KEY_C},
        '{KEY_STAR, 4'd0, KEY_HASH, KEY_D}
    };

    typedef struct packed {
        logic       hit;
        logic [1:0] row;
    } hit_t;

    // A hit is exactly one low row; no low row or several low rows are rejected.
    function automatic hit_t decode_rows(input logic [3:0] rows);
        hit_t h;
        case (rows)
            4'b1110: begin h.hit = 1'b1; h.row = 2'd0; end
            4'b1101: begin h.hit = 1'b1; h.row = 2'd1; end
            4'b1011: begin h.hit = 1'b1; h.row = 2'd2; end
            4'b0111: begin h.hit = 1'b1; h.row = 2'd3; end
            default: begin h.hit = 1'b0; h.row = 2'd0; end
        endcase
        return h;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad rows into the clk domain.
module keypad_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows_in,
    output logic [3:0] rows_s
);

    logic [3:0] meta_d;
    logic [3:0] meta_q;
    logic [3:0] sync_d;
    logic [3:0] sync_q;

    // First stage samples the pins, second stage re-samples the first stage.
    always_comb begin
        meta_d = rows_in;
        sync_d = meta_q;
    end

    // Synchronizer flops; rows read as idle (all high) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign rows_s = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates the column drive, debounces a single pressed key and
// emits one key code per press, plus a held flag until the key is released.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_number,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W:0]   DEB_TARGET = (DEB_W + 1)'(DEBOUNCE_CNT);

    logic [3:0]       rows_s;
    hit_t             hit_s;
    logic             sample_s;
    logic [DEB_W:0]   deb_inc_s;
    logic             deb_done_s;

    logic [DIV_W-1:0] dwell_d,      dwell_q;
    logic [1:0]       col_d,        col_q;
    logic [3:0]       col_out_d,    col_out_q;
    state_e           state_d,      state_q;
    logic [DEB_W-1:0] deb_d,        deb_q;
    logic [1:0]       row_d,        row_q;
    logic [3:0]       key_number_d, key_number_q;
    logic             key_valid_d,  key_valid_q;
    logic             key_held_d,   key_held_q;

    keypad_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rows_in (row_in),
        .rows_s  (rows_s)
    );

    assign hit_s      = decode_rows(rows_s);
    assign sample_s   = (dwell_q == DIV_LAST);
    // One extra bit keeps the increment from wrapping before the compare.
    assign deb_inc_s  = {1'b0, deb_q} + {{DEB_W{1'b0}}, 1'b1};
    assign deb_done_s = (deb_inc_s >= DEB_TARGET);

    // Next-state logic: dwell timer, column rotation, debounce FSM and key outputs.
    always_comb begin
        dwell_d      = sample_s ? '0 : (dwell_q + DIV_W'(1'b1));
        state_d      = state_q;
        col_d        = col_q;
        deb_d        = deb_q;
        row_d        = row_q;
        key_number_d = key_number_q;
        key_valid_d  = 1'b0;
        key_held_d   = key_held_q;

        if (sample_s) begin
            case (state_q)
                SCAN: begin
                    if (hit_s.hit) begin
                        // Column stays frozen on the key that was found.
                        row_d = hit_s.row;
                        if (deb_done_s) begin
                            key_number_d = KEYMAP[hit_s.row][col_q];
                            key_valid_d  = 1'b1;
                            key_held_d   = 1'b1;
                            deb_d        = '0;
                            state_d      = PRESSED;
                        end else begin
                            deb_d   = deb_inc_s[DEB_W-1:0];
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (hit_s.hit && (hit_s.row == row_q)) begin
                        if (deb_done_s) begin
                            key_number_d = KEYMAP[row_q][col_q];
                            key_valid_d  = 1'b1;
                            key_held_d   = 1'b1;
                            deb_d        = '0;
                            state_d      = PRESSED;
                        end else begin
                            deb_d = deb_inc_s[DEB_W-1:0];
                        end
                    end else begin
                        // Bounce or a different pattern: give up and keep scanning.
                        deb_d   = '0;
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                PRESSED: begin
                    if (rows_s == 4'b1111) begin
                        if (deb_done_s) begin
                            key_held_d = 1'b0;
                            deb_d      = '0;
                            col_d      = col_q + 2'd1;
                            state_d    = SCAN;
                        end else begin
                            deb_d = deb_inc_s[DEB_W-1:0];
                        end
                    end else begin
                        // Any low row (original key or extra keys) restarts release timing.
                        deb_d = '0;
                    end
                end
                default: begin
                    deb_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        col_out_d = ~(4'b0001 << col_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q      <= '0;
            col_q        <= 2'd0;
            col_out_q    <= 4'b1110;
            state_q      <= SCAN;
            deb_q        <= '0;
            row_q        <= 2'd0;
            key_number_q <= 4'd0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            dwell_q      <= dwell_d;
            col_q        <= col_d;
            col_out_q    <= col_out_d;
            state_q      <= state_d;
            deb_q        <= deb_d;
            row_q        <= row_d;
            key_number_q <= key_number_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign col_out    = col_out_q;
    assign key_number = key_number_q;
    assign key_valid  = key_valid_q;
    assign key_held   = key_held_q;

endmodule
